// File: rtl/jtroadf_pkg.sv
// Shared types for the Road Fighter video ROM read arbiter.
// FSM state encoding and requester ids.
package jtroadf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic SCR = 1'b0;
  localparam logic OBJ = 1'b1;

endpackage

// File: rtl/jtroadf_rom_buf.sv
// One-word result buffer for a ROM requester.
// Holds tag/valid/data and flags hit or miss for the current address.
module jtroadf_rom_buf #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic          wval_i,
  input  logic [AW-1:0] wtag_i,
  input  logic [31:0]   wdata_i,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  output logic          ok_o,
  output logic          miss_o,
  output logic [31:0]   data_o
);

  logic [AW-1:0] tag_q;
  logic          val_q;
  logic [31:0]   data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (we_i) begin
        tag_q  <= wtag_i;
        data_q <= wdata_i;
        val_q  <= wval_i;
      end
      // Download invalidates regardless of any write this cycle
      if (clr_i) val_q <= 1'b0;
    end
  end

  assign ok_o   = cs_i & val_q & (addr_i == tag_q);
  assign miss_o = cs_i & ~ok_o;
  assign data_o = data_q;

endmodule

// File: rtl/jtroadf_rom_arb.sv
// Scroll/object SDRAM read arbiter with per-requester word buffers.
// Round-robin grant, one outstanding read, download discards in-flight data.
module jtroadf_rom_arb
  import jtroadf_pkg::*;
#(
  parameter int          SCR_AW     = 15,
  parameter int          OBJ_AW     = 15,
  parameter logic [21:0] SCR_OFFSET = 22'h0,
  parameter logic [21:0] OBJ_OFFSET = 22'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dwn,
  input  logic              scr_cs,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [31:0]       scr_data,
  output logic              scr_ok,
  input  logic              obj_cs,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [31:0]       obj_data,
  output logic              obj_ok,
  output logic [21:0]       mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic              mem_rdy,
  input  logic [31:0]       mem_data
);

  localparam int TW = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          disc_q, disc_d;
  logic          rd_q, rd_d;
  logic [21:0]   addr_q, addr_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          store;
  logic          wval;
  logic          scr_miss, obj_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= SCR;
      last_q  <= OBJ;
      disc_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      disc_q  <= disc_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    disc_d  = disc_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    store   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!dwn && (scr_miss || obj_miss)) begin
          gnt_d = (obj_miss && (!scr_miss || last_q == SCR))
                ? OBJ : SCR;
          last_d  = gnt_d;
          disc_d  = 1'b0;
          rd_d    = 1'b1;
          state_d = ST_REQ;
          if (gnt_d == SCR) begin
            addr_d = SCR_OFFSET + 22'(scr_addr);
            tag_d  = TW'(scr_addr);
          end else begin
            addr_d = OBJ_OFFSET + 22'(obj_addr);
            tag_d  = TW'(obj_addr);
          end
        end
      end
      ST_REQ: begin
        disc_d = disc_q | dwn;
        if (mem_ack) begin
          rd_d = 1'b0;
          // Ack and data together: finish the fetch now
          if (mem_rdy) begin
            store   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        disc_d = disc_q | dwn;
        if (mem_rdy) begin
          store   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wval     = ~(disc_q | dwn);
  assign mem_rd   = rd_q;
  assign mem_addr = addr_q;

  jtroadf_rom_buf #(.AW(SCR_AW)) u_scr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (dwn),
    .we_i    (store & (gnt_q == SCR)),
    .wval_i  (wval),
    .wtag_i  (tag_q[SCR_AW-1:0]),
    .wdata_i (mem_data),
    .cs_i    (scr_cs),
    .addr_i  (scr_addr),
    .ok_o    (scr_ok),
    .miss_o  (scr_miss),
    .data_o  (scr_data)
  );

  jtroadf_rom_buf #(.AW(OBJ_AW)) u_obj (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (dwn),
    .we_i    (store & (gnt_q == OBJ)),
    .wval_i  (wval),
    .wtag_i  (tag_q[OBJ_AW-1:0]),
    .wdata_i (mem_data),
    .cs_i    (obj_cs),
    .addr_i  (obj_addr),
    .ok_o    (obj_ok),
    .miss_o  (obj_miss),
    .data_o  (obj_data)
  );

endmodule

// File: tb/tb_jtroadf_rom_arb.sv
// Bench for jtroadf_rom_arb: directed scenarios plus a random run,
// checked every cycle against a transaction-level model.
module tb_jtroadf_rom_arb;

  localparam logic [21:0] SOFF = 22'h10000;
  localparam logic [21:0] OOFF = 22'h3FC000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dwn = 1'b0;
  logic        scr_cs = 1'b0;
  logic        obj_cs = 1'b0;
  logic [14:0] scr_addr = '0;
  logic [14:0] obj_addr = '0;
  logic        mem_ack = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok, mem_rd;
  logic [21:0] mem_addr;

  jtroadf_rom_arb #(
    .SCR_AW(15), .OBJ_AW(15),
    .SCR_OFFSET(SOFF), .OBJ_OFFSET(OOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dwn(dwn),
    .scr_cs(scr_cs), .scr_addr(scr_addr),
    .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr),
    .obj_data(obj_data), .obj_ok(obj_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_rdy(mem_rdy),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: buffers plus one outstanding fetch
  logic        m_val [2];
  logic [14:0] m_tag [2];
  logic [31:0] m_data [2];
  logic        busy, acked, disc, fin, sm, om;
  int          g, last;
  logic [14:0] ftag;
  logic [21:0] faddr;

  function automatic logic [21:0] wrap22(input logic [21:0] off,
                                         input logic [14:0] a);
    int s;
    s = int'(off) + int'(a);
    return 22'(s % (1 << 22));
  endfunction

  task automatic model_reset();
    busy = 0; acked = 0; disc = 0; last = 1; g = 0;
    ftag = '0; faddr = '0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
  endtask

  always @(posedge clk) if (rst_n) begin
    sm = scr_cs && !(m_val[0] && m_tag[0] == scr_addr);
    om = obj_cs && !(m_val[1] && m_tag[1] == obj_addr);
    fin = 0;
    if (busy) begin
      if (dwn) disc = 1;
      if (!acked) begin
        if (mem_ack) begin
          acked = 1;
          if (mem_rdy) fin = 1;
        end
      end else if (mem_rdy) fin = 1;
      if (fin) begin
        m_tag[g] = ftag;
        m_data[g] = mem_data;
        m_val[g] = !disc;
        busy = 0;
      end
    end else if (!dwn && (sm || om)) begin
      g = (sm && om) ? 1 - last : (sm ? 0 : 1);
      last = g; busy = 1; acked = 0; disc = 0;
      ftag  = g ? obj_addr : scr_addr;
      faddr = g ? wrap22(OOFF, obj_addr) : wrap22(SOFF, scr_addr);
    end
    if (dwn) begin
      m_val[0] = 0; m_val[1] = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("scr_ok", scr_ok,
        scr_cs && m_val[0] && m_tag[0] == scr_addr);
    chk("obj_ok", obj_ok,
        obj_cs && m_val[1] && m_tag[1] == obj_addr);
    chk("scr_data", scr_data, m_data[0]);
    chk("obj_data", obj_data, m_data[1]);
    chk("mem_rd", mem_rd, busy && !acked);
    if (busy && !acked) chk("mem_addr", mem_addr, faddr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!mem_rd && n < 20) begin
      tick();
      n++;
    end
    chk("rd_wait", mem_rd, 1'b1);
  endtask

  task automatic pulse_ack();
    mem_ack = 1; tick(); mem_ack = 0;
  endtask

  task automatic pulse_rdy(input logic [31:0] d);
    mem_rdy = 1; mem_data = d; tick(); mem_rdy = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  logic [21:0] rr_exp [4];

  initial begin
    model_reset();
    #3;
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_addr", mem_addr, 22'h0);
    chk("rst_sok", scr_ok, 1'b0);
    chk("rst_odata", obj_data, 32'h0);
    tick(); tick();
    rst_n = 1;

    // Single scroll miss, then hit
    scr_cs = 1; scr_addr = 15'h0123;
    chk("t1_ok0", scr_ok, 1'b0);
    tick();
    chk("t1_rd", mem_rd, 1'b1);
    chk("t1_addr", mem_addr, 22'h10123);
    tick();
    pulse_ack();
    chk("t1_rd_drop", mem_rd, 1'b0);
    tick(); tick();
    pulse_rdy(32'hDEADBEEF);
    chk("t1_ok", scr_ok, 1'b1);
    chk("t1_data", scr_data, 32'hDEADBEEF);
    tick();
    chk("t1_hit_nord", mem_rd, 1'b0);
    chk("t1_hit_ok", scr_ok, 1'b1);

    // Round-robin over four ties
    scr_cs = 0;
    do_reset();
    rr_exp[0] = 22'h10100; rr_exp[1] = 22'h3FC200;
    rr_exp[2] = 22'h10101; rr_exp[3] = 22'h3FC201;
    scr_cs = 1; obj_cs = 1;
    scr_addr = 15'h100; obj_addr = 15'h200;
    for (int k = 0; k < 4; k++) begin
      wait_rd();
      chk("rr_addr", mem_addr, rr_exp[k]);
      pulse_ack();
      if (k % 2 == 0) scr_addr = scr_addr + 15'd1;
      else obj_addr = obj_addr + 15'd1;
      pulse_rdy(32'(k));
      if (k == 3) begin
        scr_cs = 0; obj_cs = 0;
      end
    end

    // Address change mid-fetch
    scr_cs = 1; scr_addr = 15'h10;
    wait_rd();
    chk("ac_addr0", mem_addr, 22'h10010);
    pulse_ack();
    scr_addr = 15'h11;
    tick();
    pulse_rdy(32'hA);
    chk("ac_ok0", scr_ok, 1'b0);
    chk("ac_data0", scr_data, 32'hA);
    wait_rd();
    chk("ac_addr1", mem_addr, 22'h10011);
    pulse_ack();
    pulse_rdy(32'hB);
    chk("ac_ok1", scr_ok, 1'b1);

    // Download during WAIT
    scr_addr = 15'h40;
    wait_rd();
    pulse_ack();
    dwn = 1;
    tick();
    pulse_rdy(32'hC);
    chk("dw_ok", scr_ok, 1'b0);
    tick();
    chk("dw_nord0", mem_rd, 1'b0);
    tick();
    chk("dw_nord1", mem_rd, 1'b0);
    dwn = 0;
    wait_rd();
    chk("dw_addr", mem_addr, 22'h10040);
    pulse_ack();
    pulse_rdy(32'hD);
    chk("dw_ok1", scr_ok, 1'b1);

    // Ack and rdy together; object address wraps modulo 2^22
    scr_cs = 0; obj_cs = 1; obj_addr = 15'h7FFF;
    wait_rd();
    chk("ar_addr", mem_addr, 22'h003FFF);
    mem_ack = 1; mem_rdy = 1; mem_data = 32'h12345678;
    tick();
    mem_ack = 0; mem_rdy = 0;
    chk("ar_ok", obj_ok, 1'b1);
    chk("ar_data", obj_data, 32'h12345678);
    tick();
    chk("ar_idle", mem_rd, 1'b0);

    // Asynchronous reset while in REQ
    scr_cs = 1; scr_addr = 15'h55;
    wait_rd();
    chk("rq_objhit", obj_ok, 1'b1);
    #2;
    rst_n = 0; model_reset();
    #1;
    chk("rq_rd", mem_rd, 1'b0);
    chk("rq_ook", obj_ok, 1'b0);
    chk("rq_addr", mem_addr, 22'h0);
    scr_cs = 0; obj_cs = 0;
    tick(); tick();
    rst_n = 1;
    pulse_rdy(32'hFFFFFFFF);
    scr_cs = 1; obj_cs = 1; scr_addr = '0; obj_addr = '0;
    #1;
    chk("st_sok", scr_ok, 1'b0);
    chk("st_ook", obj_ok, 1'b0);
    chk("st_sdata", scr_data, 32'h0);
    chk("st_odata", obj_data, 32'h0);

    // Random traffic with model-driven memory responder
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) scr_cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) obj_cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        scr_addr = 15'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        obj_addr = 15'h7FFC + 15'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) dwn = ~dwn;
      mem_ack = busy && !acked && ($urandom_range(0, 2) == 0);
      if (busy && acked) mem_rdy = ($urandom_range(0, 2) == 0);
      else if (busy) mem_rdy = ($urandom_range(0, 3) == 0);
      else mem_rdy = ($urandom_range(0, 19) == 0);
      mem_data = $urandom;
      tick();
    end
    dwn = 0; mem_ack = 0; mem_rdy = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
